// File: rtl/rf_alu_pkg.sv
// Shared types for the word-serial ALU sequencer: op encoding, FSM states, default latency.
package rf_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ALU_LAT = 7;

endpackage

// File: rtl/rf_alu_slice_ctl.sv
// Combinational map from (op, slice index, carry register) to the seven 2-bit ALU slice controls.
module rf_alu_slice_ctl
  import rf_alu_pkg::*;
#(
  parameter int NSLICE = 4,
  parameter int IDX_W  = 2
) (
  input  logic             issue,
  input  op_e              op,
  input  logic [IDX_W-1:0] idx,
  input  logic             carry,
  output logic             carry_in,
  output logic             end_bar,
  output logic             cmpl_x,
  output logic             cmpl_y,
  output logic             op_and,
  output logic             op_xor,
  output logic             op_arith
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  logic first;
  assign first = (idx == '0);

  always_comb begin
    carry_in = 1'b0;
    end_bar  = 1'b1;
    cmpl_x   = 1'b0;
    cmpl_y   = 1'b0;
    op_and   = 1'b0;
    op_xor   = 1'b0;
    op_arith = 1'b0;
    if (issue) begin
      end_bar = (idx != LAST_IDX);
      case (op)
        OP_ADD: begin
          op_arith = 1'b1;
          carry_in = first ? 1'b0 : carry;
        end
        // Two's-complement subtract: invert y and inject the +1 on slice 0.
        OP_SUB: begin
          op_arith = 1'b1;
          cmpl_y   = 1'b1;
          carry_in = first ? 1'b1 : carry;
        end
        OP_AND:  op_and = 1'b1;
        default: op_xor = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/rf_alu_word_seq.sv
// Sequences a WORD_W-bit op through an external 2-bit ALU stage, LSB slice first, ALU_LAT clocks per slice.
// Optional RF_ALU_SEQ_OVF_EN: capture last-slice signed overflow into out_ovf. WORD_W must be even and >= 2.
module rf_alu_word_seq
  import rf_alu_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int ALU_LAT = DEF_ALU_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [1:0]        alu_xin,
  output logic [1:0]        alu_yin,
  output logic              alu_carry_in,
  output logic              alu_end_bar,
  output logic              alu_cmpl_x,
  output logic              alu_cmpl_y,
  output logic              alu_op_and,
  output logic              alu_op_xor,
  output logic              alu_op_arith,
  input  logic [1:0]        alu_zout,
  input  logic              alu_carry_out,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] result,
  output logic              out_carry,
  output logic              out_ovf
);

  localparam int NSLICE = WORD_W / 2;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int CNT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

  state_e            state;
  op_e               op_q;
  logic [WORD_W-1:0] a_q, b_q, res_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  wcnt;
  logic              carry_q;
  logic              issue, capture, arith;

  assign issue   = (state == ST_ISSUE);
  assign capture = (state == ST_WAIT) && (wcnt == LAST_CNT);
  assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
      wcnt    <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q  <= op_e'(op);
          a_q   <= a;
          b_q   <= b;
          idx   <= '0;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          wcnt  <= '0;
          state <= ST_WAIT;
        end
        // Capture lands exactly ALU_LAT clocks after the ISSUE edge.
        ST_WAIT: if (capture) begin
          res_q[2*idx +: 2] <= alu_zout;
          carry_q           <= arith & alu_carry_out;
          if (idx == LAST_IDX) state <= ST_DONE;
          else begin
            idx   <= idx + 1'b1;
            state <= ST_ISSUE;
          end
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RF_ALU_SEQ_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (capture) ovf_q <= arith & alu_overflow;
  end
  assign out_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
  assign out_ovf    = 1'b0;
`endif

  assign alu_xin = issue ? a_q[2*idx +: 2] : 2'b00;
  assign alu_yin = issue ? b_q[2*idx +: 2] : 2'b00;

  rf_alu_slice_ctl #(.NSLICE(NSLICE), .IDX_W(IDX_W)) u_ctl (
    .issue    (issue),
    .op       (op_q),
    .idx      (idx),
    .carry    (carry_q),
    .carry_in (alu_carry_in),
    .end_bar  (alu_end_bar),
    .cmpl_x   (alu_cmpl_x),
    .cmpl_y   (alu_cmpl_y),
    .op_and   (alu_op_and),
    .op_xor   (alu_op_xor),
    .op_arith (alu_op_arith)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = res_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_rf_alu_word_seq.sv
// Bench for rf_alu_word_seq: behavioural 2-bit ALU stage plus word-level reference arithmetic.
module tb_rf_alu_word_seq;

  localparam int WORD_W  = 8;
  localparam int ALU_LAT = 7;
  localparam int NSLICE  = WORD_W / 2;
  localparam int LAT     = NSLICE * (ALU_LAT + 1) + 1;
`ifdef RF_ALU_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        op = 2'b00;
  logic [WORD_W-1:0] a = '0, b = '0;
  logic [1:0]        alu_xin, alu_yin, alu_zout;
  logic              alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
  logic              alu_op_and, alu_op_xor, alu_op_arith;
  logic              alu_carry_out, alu_overflow;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] result;
  logic              out_carry, out_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_alu_word_seq #(.WORD_W(WORD_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .alu_xin(alu_xin), .alu_yin(alu_yin),
    .alu_carry_in(alu_carry_in), .alu_end_bar(alu_end_bar),
    .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y),
    .alu_op_and(alu_op_and), .alu_op_xor(alu_op_xor), .alu_op_arith(alu_op_arith),
    .alu_zout(alu_zout), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_carry(out_carry), .out_ovf(out_ovf)
  );

  // Behavioural 2-bit ALU stage: inputs sampled at a clock edge appear ALU_LAT edges later.
  function automatic logic [3:0] alu_f(input logic [1:0] xi, yi, input logic ci, cx, cy, an, xo, ar);
    logic [1:0] x, y, z;
    logic [2:0] s;
    x = xi ^ {2{cx}};
    y = yi ^ {2{cy}};
    if (ar) begin
      s = {1'b0, x} + {1'b0, y} + {2'b00, ci};
      z = s[1:0];
      return {(x[1] == y[1]) && (z[1] != x[1]), s[2], z};
    end else if (an) return {2'b00, x & y};
    else if (xo)     return {2'b00, x ^ y};
    return 4'h0;
  endfunction

  logic [3:0] pipe [ALU_LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_xin, alu_yin, alu_carry_in, alu_cmpl_x, alu_cmpl_y,
                     alu_op_and, alu_op_xor, alu_op_arith);
    for (int j = 1; j < ALU_LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign alu_zout      = pipe[ALU_LAT-1][1:0];
  assign alu_carry_out = pipe[ALU_LAT-1][2];
  assign alu_overflow  = pipe[ALU_LAT-1][3];

  // Word-level reference: plain arithmetic on whole operands.
  task automatic ref_calc(input logic [1:0] o, input logic [WORD_W-1:0] x, y,
                          output logic [WORD_W-1:0] r, output logic c, v);
    logic [WORD_W:0] s;
    c = 1'b0; v = 1'b0;
    case (o)
      2'b00: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[WORD_W-1:0]; c = s[WORD_W];
        v = (x[WORD_W-1] == y[WORD_W-1]) && (r[WORD_W-1] != x[WORD_W-1]);
      end
      2'b01: begin
        s = {1'b0, x} + {1'b0, ~y} + 1'b1;
        r = s[WORD_W-1:0]; c = s[WORD_W];
        v = (x[WORD_W-1] != y[WORD_W-1]) && (r[WORD_W-1] != x[WORD_W-1]);
      end
      2'b10:   r = x & y;
      default: r = x ^ y;
    endcase
    v = v & OVF_EN;
  endtask

  // Issue one command and watch the ALU port until out_valid (or cycle stop_at).
  task automatic run_cmd(input logic [1:0] o, input logic [WORD_W-1:0] x, y, input int stop_at,
                         output logic [WORD_W-1:0] r, output logic c, v,
                         output int lat, output int perr, output logic cin_any);
    int n, iss, waitc;
    perr = 0; cin_any = 1'b0; lat = -1; iss = 0; r = '0; c = 1'b0; v = 1'b0;
    waitc = 0;
    while (!in_ready && waitc < 100) begin @(negedge clk); waitc++; end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (n <= 200) begin
      if (alu_op_arith || alu_op_and || alu_op_xor) begin
        if (alu_end_bar !== (iss != NSLICE - 1)) perr++;
        if (alu_cmpl_x !== 1'b0) perr++;
        if (iss < NSLICE && (alu_xin !== x[2*iss +: 2] || alu_yin !== y[2*iss +: 2])) perr++;
        cin_any |= alu_carry_in;
        iss++;
      end else if ({alu_xin, alu_yin, alu_carry_in, alu_cmpl_x, alu_cmpl_y} !== 7'd0 ||
                   alu_end_bar !== 1'b1) perr++;
      if (out_valid || (stop_at > 0 && n == stop_at)) break;
      @(negedge clk);
      n++;
    end
    if (out_valid) begin lat = n; r = result; c = out_carry; v = out_ovf; end
    if (stop_at == 0 && iss != NSLICE) perr++;
  endtask

  task automatic finish_cmd();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if ({alu_xin, alu_yin, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y, alu_op_and, alu_op_xor, alu_op_arith} !== 13'b0000_0_1_00000) begin
      failures++;
      $display("FAIL reset_alu_outs got=%b want=%b", {alu_xin, alu_yin, alu_carry_in, alu_end_bar,
               alu_cmpl_x, alu_cmpl_y, alu_op_and, alu_op_xor, alu_op_arith}, 13'b0000_0_1_00000);
    end
    checks++; if ({result, out_carry, out_ovf} !== '0) begin failures++; $display("FAIL reset_result got=%h/%b/%b want=0", result, out_carry, out_ovf); end
  endtask

  // One directed command compared fully against the reference.
  task automatic test_directed(input string name, input logic [1:0] o, input logic [WORD_W-1:0] x, y);
    logic [WORD_W-1:0] r, er;
    logic c, v, ec, ev, cin;
    int lat, perr;
    ref_calc(o, x, y, er, ec, ev);
    run_cmd(o, x, y, 0, r, c, v, lat, perr, cin);
    checks++; if (r !== er) begin failures++; $display("FAIL %s_result got=%h want=%h", name, r, er); end
    checks++; if (c !== ec) begin failures++; $display("FAIL %s_carry got=%b want=%b", name, c, ec); end
    checks++; if (v !== ev) begin failures++; $display("FAIL %s_ovf got=%b want=%b", name, v, ev); end
    checks++; if (lat != LAT) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
    checks++; if (perr != 0) begin failures++; $display("FAIL %s_alu_port errors=%0d want=0", name, perr); end
    if (o[1]) begin
      checks++; if (cin !== 1'b0) begin failures++; $display("FAIL %s_carry_in got=%b want=0", name, cin); end
    end
    finish_cmd();
  endtask

  task automatic test_add_sub_logic();
    test_directed("add_7f_01", 2'b00, 8'h7F, 8'h01);
    test_directed("sub_05_07", 2'b01, 8'h05, 8'h07);
    test_directed("sub_07_05", 2'b01, 8'h07, 8'h05);
    test_directed("and_f0_3c", 2'b10, 8'hF0, 8'h3C);
    test_directed("xor_ff_0f", 2'b11, 8'hFF, 8'h0F);
  endtask

  // DONE with out_ready low: outputs frozen, no new issue, no accept until after the handshake.
  task automatic test_hold();
    logic [WORD_W-1:0] r, er;
    logic c, v, ec, ev, cin;
    int lat, perr;
    ref_calc(2'b01, 8'h80, 8'h01, er, ec, ev);
    run_cmd(2'b01, 8'h80, 8'h01, 0, r, c, v, lat, perr, cin);
    checks++; if (r !== er || c !== ec || v !== ev) begin failures++; $display("FAIL hold_first got=%h/%b/%b want=%h/%b/%b", r, c, v, er, ec, ev); end
    in_valid = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({result, out_carry, out_ovf} !== {er, ec, ev}) begin failures++; $display("FAIL hold_stable cyc=%0d got=%h/%b/%b want=%h/%b/%b", i, result, out_carry, out_ovf, er, ec, ev); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL hold_handshake cyc=%0d got=%b%b want=10", i, out_valid, in_ready); end
      checks++; if ({alu_op_and, alu_op_xor, alu_op_arith} !== 3'b000) begin failures++; $display("FAIL hold_no_issue cyc=%0d got=%b want=000", i, {alu_op_and, alu_op_xor, alu_op_arith}); end
    end
    finish_cmd();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%b%b want=01", out_valid, in_ready); end
    @(negedge clk);
    // in_valid was held high through DONE; first accept is the IDLE cycle after the handshake.
    checks++; if (alu_op_arith !== 1'b1) begin failures++; $display("FAIL hold_next_issue got=%b want=1", alu_op_arith); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_midreset();
    logic [WORD_W-1:0] r;
    logic c, v, cin;
    int lat, perr;
    // Cycle 20 after accept is inside WAIT of slice 2 (ISSUE at 17, WAIT 18..24).
    run_cmd(2'b00, 8'hAB, 8'hCD, 20, r, c, v, lat, perr, cin);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset_state got=%b%b want=01", out_valid, in_ready); end
    checks++;
    if ({alu_xin, alu_yin, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y, alu_op_and, alu_op_xor, alu_op_arith} !== 13'b0000_0_1_00000) begin
      failures++; $display("FAIL midreset_alu_outs end_bar=%b arith=%b", alu_end_bar, alu_op_arith);
    end
    checks++; if ({result, out_carry, out_ovf} !== '0) begin failures++; $display("FAIL midreset_result got=%h/%b/%b want=0", result, out_carry, out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_directed("midreset_add_01_01", 2'b00, 8'h01, 8'h01);
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] r, er, x, y;
    logic [1:0] o;
    logic c, v, ec, ev, cin;
    int lat, perr;
    for (int i = 0; i < 14; i++) begin
      o = 2'($urandom_range(0, 3));
      x = WORD_W'($urandom());
      y = WORD_W'($urandom());
      ref_calc(o, x, y, er, ec, ev);
      run_cmd(o, x, y, 0, r, c, v, lat, perr, cin);
      checks++; if (r !== er || c !== ec || v !== ev) begin failures++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h/%b/%b want=%h/%b/%b", i, o, x, y, r, c, v, er, ec, ev); end
      checks++; if (lat != LAT || perr != 0) begin failures++; $display("FAIL rand%0d_timing lat=%0d want=%0d port_errs=%0d", i, lat, LAT, perr); end
      checks++; if (o[1] && cin !== 1'b0) begin failures++; $display("FAIL rand%0d_carry_in got=%b want=0", i, cin); end
      finish_cmd();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_logic();
    test_hold();
    test_midreset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
